sram_fifo_1r1w: RTL

- Parametrised single-clock FIFO built around an inferred 1r1w SRAM array with a registered (1-cycle) read port.
- Successor to the fixed 16x8 1r1w macro wrapper: width and depth are generic; adds valid/ready handshakes, occupancy tracking and a 2-entry output buffer for full-throughput first-word-fall-through reads.
- Sits between producer/consumer stages in the training datapath.

---
 rtl/sram_fifo_1r1w_if.sv | 23 ++
 rtl/sram_fifo_1r1w.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sram_fifo_1r1w_if.sv
// Stream handshake bundle for sram_fifo_1r1w: producer side, consumer side and occupancy.
interface sram_fifo_1r1w_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH+1:0] level;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/sram_fifo_1r1w.sv
// Single-clock FIFO on an inferred 1r1w SRAM (registered read) with a 2-entry FWFT output buffer.
// Optional status outputs (almost_full, almost_empty, overflow_err) under SRAM_FIFO_STATUS_EN.
module sram_fifo_1r1w #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_TH  = 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_fifo_1r1w_if.slave io
`ifdef SRAM_FIFO_STATUS_EN
    ,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow_err
`endif
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LW        = ADDR_WIDTH + 2;
    localparam int CW        = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] CAP = LW'(RAM_DEPTH + 2);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic [1:0]            rst_sync_q, rst_sync_d;
    logic                  rst_int_n;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         arr_cnt_q, arr_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]            occ_q, occ_d, occ_sum;
    logic [LW-1:0]         level_q, level_d;
    logic                  push, pop, issue;

    // Assertion clears everything at once; release is retimed to clk.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign io.in_ready  = (level_q < CAP);
    assign io.out_valid = (occ_q != 2'd0);
    assign io.out_data  = buf0_q;
    assign io.level     = level_q;

    assign push    = io.in_valid && io.in_ready;
    assign pop     = io.out_valid && io.out_ready;
    assign occ_sum = occ_q + {1'b0, inflight_q};
    // A read may be issued into the slot that a same-cycle pop is vacating.
    assign issue   = (arr_cnt_q != '0) && ((occ_sum < 2'd2) || ((occ_sum == 2'd2) && pop));

    always_ff @(posedge clk) begin
        if (push)  mem[wr_ptr_q] <= io.in_data;
        if (issue) ram_rdata     <= mem[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        inflight_d = issue;

        arr_cnt_d = arr_cnt_q;
        case ({push, issue})
            2'b10:   arr_cnt_d = arr_cnt_q + 1'b1;
            2'b01:   arr_cnt_d = arr_cnt_q - 1'b1;
            default: arr_cnt_d = arr_cnt_q;
        endcase

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        if (pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        // Returning read lands behind whatever survives the pop.
        if (inflight_q) begin
            if (occ_d == 2'd0) buf0_d = ram_rdata;
            else               buf1_d = ram_rdata;
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            arr_cnt_q  <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            occ_q      <= 2'd0;
            level_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            arr_cnt_q  <= arr_cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            occ_q      <= occ_d;
            level_q    <= level_d;
        end
    end

`ifdef SRAM_FIFO_STATUS_EN
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;
    logic overflow_err_q, overflow_err_d;

    always_comb begin
        almost_full_d  = (level_d >= (CAP - LW'(ALMOST_FULL_TH)));
        almost_empty_d = (level_d <= LW'(ALMOST_EMPTY_TH));
        overflow_err_d = overflow_err_q | (io.in_valid & ~io.in_ready);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow_err = overflow_err_q;
`else
    logic unused_status_th;
    assign unused_status_th = ^{ALMOST_FULL_TH, ALMOST_EMPTY_TH};
`endif
endmodule
